// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM with retired-instruction counter and illegal-opcode trap.
// Optional memory wait-state handshake (mem_ready port) is enabled by defining MC_CTRL_MEM_WAIT_EN.
module mc_control_fsm #(
  parameter int CNT_W        = 32,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op,
  output logic [3:0]       state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;
  localparam logic [3:0] S_IDLE   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0]       r_state;
  logic [3:0]       w_nextState;
  logic [CNT_W-1:0] r_count;
  logic             w_memReady;

  // Without the handshake, memory is assumed to answer in a single cycle.
`ifdef MC_CTRL_MEM_WAIT_EN
  assign w_memReady = mem_ready;
`else
  assign w_memReady = 1'b1;
`endif

  always_comb begin
    w_nextState = S_IDLE;
    case (r_state)
      S_IDLE:   w_nextState = S_FETCH;
      S_FETCH:  w_nextState = w_memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   w_nextState = S_MEMADR;
          OP_RTYPE:       w_nextState = S_EXEC;
          OP_BEQ, OP_BNE: w_nextState = S_BRANCH;
          OP_ADDI:        w_nextState = S_ADDIEX;
          OP_J:           w_nextState = S_JUMP;
          default:        w_nextState = (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: w_nextState = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_nextState = w_memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_nextState = S_FETCH;
      S_MEMWR:  w_nextState = w_memReady ? S_FETCH : S_MEMWR;
      S_EXEC:   w_nextState = S_ALUWB;
      S_ALUWB:  w_nextState = S_FETCH;
      S_BRANCH: w_nextState = S_FETCH;
      S_ADDIEX: w_nextState = S_ADDIWB;
      S_ADDIWB: w_nextState = S_FETCH;
      S_JUMP:   w_nextState = S_FETCH;
      S_TRAP:   w_nextState = S_TRAP;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = w_memReady;
        pc_en     = w_memReady;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = w_memReady;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      // bne shares the beq datapath; only the sense of the zero flag flips.
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_en      = (opcode == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP:  illegal_op = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      if (instr_done)
        r_count <= r_count + CNT_W'(1);
    end
  end

  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm: a 4-bit-counter trapping instance and a
// 32-bit-counter non-trapping instance share stimulus; wait-state steps run when MC_CTRL_MEM_WAIT_EN is defined.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       zero = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif

  always #5 clk = ~clk;

  logic       pcEnA, iOrDA, memReadA, memWriteA, irWriteA, regDstA, memToRegA, regWriteA;
  logic       aluSrcAA, instrDoneA, illegalOpA;
  logic [1:0] pcSrcA, aluSrcBA, aluOpA;
  logic [3:0] countA, stateA;

  logic        pcEnB, iOrDB, memReadB, memWriteB, irWriteB, regDstB, memToRegB, regWriteB;
  logic        aluSrcAB, instrDoneB, illegalOpB;
  logic [1:0]  pcSrcB, aluSrcBB, aluOpB;
  logic [31:0] countB;
  logic [3:0]  stateB;

  mc_control_fsm #(.CNT_W(4), .ILLEGAL_TRAP(1)) dutA (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_en(pcEnA), .pc_src(pcSrcA), .i_or_d(iOrDA), .mem_read(memReadA),
    .mem_write(memWriteA), .ir_write(irWriteA), .reg_dst(regDstA),
    .mem_to_reg(memToRegA), .reg_write(regWriteA), .alu_src_a(aluSrcAA),
    .alu_src_b(aluSrcBA), .alu_op(aluOpA), .instr_done(instrDoneA),
    .instr_count(countA), .illegal_op(illegalOpA), .state(stateA)
  );

  mc_control_fsm #(.CNT_W(32), .ILLEGAL_TRAP(0)) dutB (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_en(pcEnB), .pc_src(pcSrcB), .i_or_d(iOrDB), .mem_read(memReadB),
    .mem_write(memWriteB), .ir_write(irWriteB), .reg_dst(regDstB),
    .mem_to_reg(memToRegB), .reg_write(regWriteB), .alu_src_a(aluSrcAB),
    .alu_src_b(aluSrcBB), .alu_op(aluOpB), .instr_done(instrDoneB),
    .instr_count(countB), .illegal_op(illegalOpB), .state(stateB)
  );

  wire [16:0] ctrlA = {pcEnA, pcSrcA, iOrDA, memReadA, memWriteA, irWriteA, regDstA,
                       memToRegA, regWriteA, aluSrcAA, aluSrcBA, aluOpA, instrDoneA, illegalOpA};

  int tests = 0;
  int fails = 0;

  function automatic logic [16:0] ctrlVec(
    input logic pcEn, input logic [1:0] pcSrc,
    input logic iOrD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA,
    input logic [1:0] aluSrcB, aluOp, input logic instrDone, illegalOp);
    return {pcEn, pcSrc, iOrD, memRead, memWrite, irWrite, regDst, memToReg, regWrite,
            aluSrcA, aluSrcB, aluOp, instrDone, illegalOp};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic z);
    opcode = op;
    zero   = z;
  endtask

  task automatic stepCheck(input string tag, input logic [3:0] expState,
                           input logic [16:0] expCtrl, input logic [3:0] expCount);
    @(posedge clk);
    #1;
    checkOutput({tag, " state"}, 32'(stateA), 32'(expState));
    checkOutput({tag, " ctrl"},  32'(ctrlA),  32'(expCtrl));
    checkOutput({tag, " count"}, 32'(countA), 32'(expCount));
  endtask

  logic [16:0] cIdle, cFetch, cDecode, cMemAdr, cMemRd, cMemWb, cMemWr, cExec, cAluWb;
  logic [16:0] cBrTaken, cBrNot, cAddiWb, cJump, cTrap, cFetchStall, cMemWrStall;

  initial begin
    cIdle       = '0;
    cFetch      = ctrlVec(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    cFetchStall = ctrlVec(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
    cDecode     = ctrlVec(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0);
    cMemAdr     = ctrlVec(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0);
    cMemRd      = ctrlVec(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    cMemWb      = ctrlVec(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0);
    cMemWr      = ctrlVec(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    cMemWrStall = ctrlVec(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    cExec       = ctrlVec(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0);
    cAluWb      = ctrlVec(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 1, 0);
    cBrTaken    = ctrlVec(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 0);
    cBrNot      = ctrlVec(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 0);
    cAddiWb     = ctrlVec(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0);
    cJump       = ctrlVec(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    cTrap       = ctrlVec(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1);

    // Two reset clocks, then release: IDLE for one edge, then FETCH.
    applyStimulus(6'b000000, 1'b0);
    @(posedge clk);
    stepCheck("reset", 4'd15, cIdle, 4'd0);
    rst_n = 1'b1;
    stepCheck("release", 4'd0, cFetch, 4'd0);

    // R-type: 0,1,6,7,0
    stepCheck("rtype decode", 4'd1, cDecode, 4'd0);
    stepCheck("rtype exec", 4'd6, cExec, 4'd0);
    stepCheck("rtype aluwb", 4'd7, cAluWb, 4'd0);
    stepCheck("rtype fetch", 4'd0, cFetch, 4'd1);

    applyStimulus(6'b100011, 1'b0);
    stepCheck("lw decode", 4'd1, cDecode, 4'd1);
    stepCheck("lw memadr", 4'd2, cMemAdr, 4'd1);
    stepCheck("lw memrd", 4'd3, cMemRd, 4'd1);
    stepCheck("lw memwb", 4'd4, cMemWb, 4'd1);
    stepCheck("lw fetch", 4'd0, cFetch, 4'd2);

    applyStimulus(6'b101011, 1'b0);
    stepCheck("sw decode", 4'd1, cDecode, 4'd2);
    stepCheck("sw memadr", 4'd2, cMemAdr, 4'd2);
    stepCheck("sw memwr", 4'd5, cMemWr, 4'd2);
    stepCheck("sw fetch", 4'd0, cFetch, 4'd3);

    applyStimulus(6'b000100, 1'b1);
    stepCheck("beq1 decode", 4'd1, cDecode, 4'd3);
    stepCheck("beq1 branch", 4'd8, cBrTaken, 4'd3);
    stepCheck("beq1 fetch", 4'd0, cFetch, 4'd4);

    applyStimulus(6'b000100, 1'b0);
    stepCheck("beq0 decode", 4'd1, cDecode, 4'd4);
    stepCheck("beq0 branch", 4'd8, cBrNot, 4'd4);
    stepCheck("beq0 fetch", 4'd0, cFetch, 4'd5);

    applyStimulus(6'b000101, 1'b0);
    stepCheck("bne0 decode", 4'd1, cDecode, 4'd5);
    stepCheck("bne0 branch", 4'd8, cBrTaken, 4'd5);
    stepCheck("bne0 fetch", 4'd0, cFetch, 4'd6);

    applyStimulus(6'b000101, 1'b1);
    stepCheck("bne1 decode", 4'd1, cDecode, 4'd6);
    stepCheck("bne1 branch", 4'd8, cBrNot, 4'd6);
    stepCheck("bne1 fetch", 4'd0, cFetch, 4'd7);

    applyStimulus(6'b001000, 1'b0);
    stepCheck("addi decode", 4'd1, cDecode, 4'd7);
    stepCheck("addi ex", 4'd9, cMemAdr, 4'd7);
    stepCheck("addi wb", 4'd10, cAddiWb, 4'd7);
    stepCheck("addi fetch", 4'd0, cFetch, 4'd8);

    applyStimulus(6'b000010, 1'b0);
    stepCheck("j decode", 4'd1, cDecode, 4'd8);
    stepCheck("j jump", 4'd11, cJump, 4'd8);
    stepCheck("j fetch", 4'd0, cFetch, 4'd9);

    // Seven more jumps take the 4-bit counter from 9 through 15 and wrap to 0.
    for (int i = 0; i < 7; i++) begin
      stepCheck("wrap decode", 4'd1, cDecode, 4'(9 + i));
      stepCheck("wrap jump", 4'd11, cJump, 4'(9 + i));
      stepCheck("wrap fetch", 4'd0, cFetch, 4'(10 + i));
    end
    checkOutput("wide count 16", countB, 32'd16);

    applyStimulus(6'b111111, 1'b0);
    stepCheck("illegal decode", 4'd1, cDecode, 4'd0);
    stepCheck("illegal trap", 4'd12, cTrap, 4'd0);
    checkOutput("notrap state", 32'(stateB), 32'd0);
    for (int i = 0; i < 10; i++)
      stepCheck("trap hold", 4'd12, cTrap, 4'd0);
    checkOutput("notrap count", countB, 32'd16);

    rst_n = 1'b0;
    stepCheck("trap reset", 4'd15, cIdle, 4'd0);
    rst_n = 1'b1;
    stepCheck("trap release", 4'd0, cFetch, 4'd0);

    // Reset in the middle of an R-type instruction.
    applyStimulus(6'b000000, 1'b0);
    stepCheck("mid decode", 4'd1, cDecode, 4'd0);
    stepCheck("mid exec", 4'd6, cExec, 4'd0);
    rst_n = 1'b0;
    stepCheck("mid reset", 4'd15, cIdle, 4'd0);
    checkOutput("wide count reset", countB, 32'd0);
    rst_n = 1'b1;
    stepCheck("mid release", 4'd0, cFetch, 4'd0);

`ifdef MC_CTRL_MEM_WAIT_EN
    applyStimulus(6'b000010, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      stepCheck("fetch stall", 4'd0, cFetchStall, 4'd0);
    mem_ready = 1'b1;
    #1;
    checkOutput("fetch ready ctrl", 32'(ctrlA), 32'(cFetch));
    stepCheck("wait decode", 4'd1, cDecode, 4'd0);
    stepCheck("wait jump", 4'd11, cJump, 4'd0);
    stepCheck("wait fetch", 4'd0, cFetch, 4'd1);

    applyStimulus(6'b101011, 1'b0);
    stepCheck("wsw decode", 4'd1, cDecode, 4'd1);
    stepCheck("wsw memadr", 4'd2, cMemAdr, 4'd1);
    mem_ready = 1'b0;
    stepCheck("wsw stall1", 4'd5, cMemWrStall, 4'd1);
    stepCheck("wsw stall2", 4'd5, cMemWrStall, 4'd1);
    mem_ready = 1'b1;
    #1;
    checkOutput("wsw ready ctrl", 32'(ctrlA), 32'(cMemWr));
    stepCheck("wsw fetch", 4'd0, cFetch, 4'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
